// File: rtl/tick_burst_controller_pkg.sv
// Shared types, default frequencies and helpers for the tick burst controller.
package tick_burst_controller_pkg;

  localparam int unsigned DEF_REF_CLK_HZ = 50_000_000;
  localparam int unsigned DEF_TICK_HZ    = 100;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } tbc_state_e;

  function automatic int unsigned ceil_log2(input longint unsigned value);
    int unsigned    bits;
    longint unsigned span;
    bits = 0;
    span = 1;
    while (span < value) begin
      span = span << 1;
      bits++;
    end
    return bits;
  endfunction

endpackage

// File: rtl/tick_burst_controller_if.sv
// Config handshake and run-control/status bundle of the tick burst controller.
interface tick_burst_controller_if #(
  parameter int unsigned DIV_WIDTH   = 26,
  parameter int unsigned COUNT_WIDTH = 16
);
  logic                   cfg_valid;
  logic                   cfg_ready;
  logic [DIV_WIDTH-1:0]   cfg_div;
  logic [COUNT_WIDTH-1:0] cfg_count;
  logic                   start;
  logic                   stop;
  logic                   tick;
  logic                   busy;
  logic                   done;
  logic [COUNT_WIDTH-1:0] ticks_left;

  modport master (
    output cfg_valid, cfg_div, cfg_count, start, stop,
    input  cfg_ready, tick, busy, done, ticks_left
  );

  modport slave (
    input  cfg_valid, cfg_div, cfg_count, start, stop,
    output cfg_ready, tick, busy, done, ticks_left
  );
endinterface

// File: rtl/tick_burst_controller_prescaler.sv
// Runtime-programmable up-counter that flags the last cycle of each period.
module tick_prescaler #(
  parameter int unsigned WIDTH = 26
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             clear_i,
  input  logic             enable_i,
  input  logic [WIDTH-1:0] div_i,
  output logic             flag_o
);

  logic [WIDTH-1:0] cnt_q, cnt_d;

  // div_i is never zero here, so div_i - 1 cannot wrap.
  assign flag_o = (cnt_q == div_i - WIDTH'(1));

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (enable_i) begin
      cnt_d = flag_o ? '0 : cnt_q + WIDTH'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/tick_burst_controller.sv
// Emits a burst of N one-cycle ticks (or a continuous train) at a programmable period.
// state | meaning
// IDLE  | accepting config, waiting for start
// RUN   | prescaler counting, ticks emitted
// DONE  | one-cycle pulse after the last tick of a finite burst
module tick_burst_controller
  import tick_burst_controller_pkg::*;
#(
  parameter int unsigned REF_CLK_HZ  = DEF_REF_CLK_HZ,
  parameter int unsigned TICK_HZ     = DEF_TICK_HZ,
  parameter int unsigned DIV_WIDTH   = 26,
  parameter int unsigned COUNT_WIDTH = 16,
  parameter int unsigned DEFAULT_DIV = REF_CLK_HZ / TICK_HZ
) (
  input logic                   clk_i,
  input logic                   rst_ni,
  tick_burst_controller_if.slave bus
);

  if (ceil_log2(longint'(DEFAULT_DIV) + 1) > DIV_WIDTH) begin : g_bad_default_div
    $error("DEFAULT_DIV does not fit in DIV_WIDTH bits");
  end

  tbc_state_e             state_q, state_d;
  logic [DIV_WIDTH-1:0]   div_q, div_d;
  logic [COUNT_WIDTH-1:0] count_q, count_d;
  logic [COUNT_WIDTH-1:0] left_q, left_d;
  logic                   presc_flag;
  logic                   presc_clear;
  logic                   tick;

  assign tick = (state_q == ST_RUN) && presc_flag;

  always_comb begin
    state_d = state_q;
    div_d   = div_q;
    count_d = count_q;
    left_d  = left_q;
    unique case (state_q)
      ST_IDLE: begin
        if (bus.cfg_valid) begin
          div_d   = (bus.cfg_div == '0) ? DIV_WIDTH'(1) : bus.cfg_div;
          count_d = bus.cfg_count;
        end
        // A config offered alongside start applies to this very run.
        if (bus.start) begin
          state_d = ST_RUN;
          left_d  = bus.cfg_valid ? bus.cfg_count : count_q;
        end
      end
      ST_RUN: begin
        if (tick && (count_q != '0)) begin
          left_d = left_q - COUNT_WIDTH'(1);
          if (left_q == COUNT_WIDTH'(1)) begin
            state_d = ST_DONE;
          end
        end
        if (bus.stop) begin
          state_d = ST_IDLE;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    presc_clear = (state_q == ST_RUN) && (state_d != ST_RUN);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ST_IDLE;
      div_q   <= DIV_WIDTH'(DEFAULT_DIV);
      count_q <= '0;
      left_q  <= '0;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      count_q <= count_d;
      left_q  <= left_d;
    end
  end

  tick_prescaler #(.WIDTH(DIV_WIDTH)) u_prescaler (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .clear_i  (presc_clear),
    .enable_i (state_q == ST_RUN),
    .div_i    (div_q),
    .flag_o   (presc_flag)
  );

  assign bus.cfg_ready  = (state_q == ST_IDLE);
  assign bus.busy       = (state_q == ST_RUN);
  assign bus.done       = (state_q == ST_DONE);
  assign bus.tick       = tick;
  assign bus.ticks_left = left_q;

endmodule

// File: tb/tb_tick_burst_controller.sv
// Directed and randomized bursts checked cycle by cycle against an arithmetic model.
module tb_tick_burst_controller;

  localparam int DW     = 26;
  localparam int CW     = 16;
  localparam int REF    = 1000;
  localparam int THZ    = 100;
  localparam int DEFDIV = REF / THZ;
  localparam int INF    = 32'h3fff_ffff;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  tick_burst_controller_if #(.DIV_WIDTH(DW), .COUNT_WIDTH(CW)) bus();

  tick_burst_controller #(
    .REF_CLK_HZ (REF),
    .TICK_HZ    (THZ),
    .DIV_WIDTH  (DW),
    .COUNT_WIDTH(CW)
  ) dut (
    .clk_i (clk),
    .rst_ni(rst_n),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;
  int mdiv;
  int mcnt;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string ctx, input logic et, input logic eb, input logic ed,
                           input logic er, input logic [31:0] etl);
    check($sformatf("%s.tick", ctx),       32'(bus.tick),       32'(et));
    check($sformatf("%s.busy", ctx),       32'(bus.busy),       32'(eb));
    check($sformatf("%s.done", ctx),       32'(bus.done),       32'(ed));
    check($sformatf("%s.cfg_ready", ctx),  32'(bus.cfg_ready),  32'(er));
    check($sformatf("%s.ticks_left", ctx), 32'(bus.ticks_left), etl);
  endtask

  // Cycle k counts from the edge that sampled start (cycle 1 follows it).
  function automatic void model(input int k, input int d, input int n, input int s,
                                output logic et, output logic eb, output logic ed,
                                output logic er, output logic [31:0] etl);
    int last_tick;
    int last_run;
    bit stopped;
    last_tick = (n > 0) ? n * d : INF;
    stopped   = (s > 0) && (s <= last_tick);
    last_run  = stopped ? s : last_tick;
    if (k <= last_run) begin
      eb  = 1'b1;
      er  = 1'b0;
      ed  = 1'b0;
      et  = ((k % d) == 0);
      etl = (n > 0) ? 32'(n - (k - 1) / d) : 32'd0;
    end else begin
      eb  = 1'b0;
      et  = 1'b0;
      ed  = !stopped && (k == last_tick + 1);
      er  = !ed;
      etl = (stopped && n > 0) ? 32'(n - s / d) : 32'd0;
    end
  endfunction

  function automatic int span(input int d, input int n, input int s);
    int last_tick;
    last_tick = (n > 0) ? n * d : INF;
    return (((s > 0) && (s <= last_tick)) ? s : last_tick) + 3;
  endfunction

  task automatic load_cfg(input int d, input int n);
    @(negedge clk);
    check("cfg_ready_before_load", 32'(bus.cfg_ready), 32'd1);
    bus.cfg_valid = 1'b1;
    bus.cfg_div   = DW'(d);
    bus.cfg_count = CW'(n);
    @(posedge clk);
    #1;
    bus.cfg_valid = 1'b0;
    mdiv = (d == 0) ? 1 : d;
    mcnt = n;
  endtask

  task automatic run(input string name, input bit cfg_now, input int d_in, input int n_in,
                     input int stop_at, input int poke_at, input int reset_at, input int ncycles);
    logic et, eb, ed, er;
    logic [31:0] etl;
    @(negedge clk);
    if (cfg_now) begin
      bus.cfg_valid = 1'b1;
      bus.cfg_div   = DW'(d_in);
      bus.cfg_count = CW'(n_in);
      mdiv = (d_in == 0) ? 1 : d_in;
      mcnt = n_in;
    end
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start     = 1'b0;
    bus.cfg_valid = 1'b0;
    for (int k = 1; k <= ncycles; k++) begin
      @(negedge clk);
      bus.stop      = 1'b0;
      bus.start     = 1'b0;
      bus.cfg_valid = 1'b0;
      model(k, mdiv, mcnt, stop_at, et, eb, ed, er, etl);
      check_all($sformatf("%s.c%0d", name, k), et, eb, ed, er, etl);
      if (k == reset_at) begin
        #2 rst_n = 1'b0;
        #1 check_all($sformatf("%s.async_reset", name), 1'b0, 1'b0, 1'b0, 1'b1, 32'd0);
        break;
      end
      if (k == stop_at) bus.stop = 1'b1;
      if (k == poke_at) begin
        bus.start     = 1'b1;
        bus.cfg_valid = 1'b1;
        bus.cfg_div   = DW'(7);
        bus.cfg_count = CW'(9);
      end
    end
    @(negedge clk);
    bus.stop      = 1'b0;
    bus.start     = 1'b0;
    bus.cfg_valid = 1'b0;
  endtask

  initial begin
    int d, n, s;
    bus.cfg_valid = 1'b0;
    bus.cfg_div   = '0;
    bus.cfg_count = '0;
    bus.start     = 1'b0;
    bus.stop      = 1'b0;
    #22;
    check_all("reset", 1'b0, 1'b0, 1'b0, 1'b1, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    mdiv  = DEFDIV;
    mcnt  = 0;

    // Defaults after reset: continuous run at DEFAULT_DIV, stopped by hand.
    run("default", 1'b0, 0, 0, 23, 0, 0, span(mdiv, mcnt, 23));

    load_cfg(4, 3);
    run("div4_cnt3", 1'b0, 0, 0, 0, 13, 0, span(4, 3, 0));

    load_cfg(0, 2);
    run("div0_cnt2", 1'b0, 0, 0, 0, 0, 0, span(1, 2, 0));

    run("cfg_with_start", 1'b1, 5, 1, 0, 0, 0, span(5, 1, 0));

    load_cfg(4, 3);
    run("stop_on_tick", 1'b0, 0, 0, 8, 2, 0, span(4, 3, 8));
    run("cfg_kept", 1'b0, 0, 0, 0, 0, 0, span(4, 3, 0));

    load_cfg(4, 5);
    run("reset_mid", 1'b0, 0, 0, 0, 0, 6, 10);
    repeat (2) @(negedge clk);
    check_all("held_in_reset", 1'b0, 1'b0, 1'b0, 1'b1, 32'd0);
    rst_n = 1'b1;
    mdiv  = DEFDIV;
    mcnt  = 0;
    run("after_reset", 1'b0, 0, 0, 12, 0, 0, span(mdiv, mcnt, 12));

    for (int it = 0; it < 8; it++) begin
      d = int'($urandom_range(0, 6));
      n = int'($urandom_range(0, 4));
      if (n == 0) s = int'($urandom_range(1, 15));
      else if ($urandom_range(0, 1) == 1) s = int'($urandom_range(1, n * ((d == 0) ? 1 : d) + 1));
      else s = 0;
      if ($urandom_range(0, 1) == 1) begin
        run($sformatf("rnd%0d", it), 1'b1, d, n, s, 0, 0, span((d == 0) ? 1 : d, n, s));
      end else begin
        load_cfg(d, n);
        run($sformatf("rnd%0d", it), 1'b0, 0, 0, s, 0, 0, span(mdiv, mcnt, s));
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
